// File: rtl/multidigit_bcd_display.sv
// Binary to multi-digit BCD converter (serial double-dabble) driving one seven-segment pattern per digit.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.

module sevenseg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // Active-low segments, bit order g..a; non-decimal codes are blank.
    always_comb begin
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module multidigit_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // 10^DIGITS - 1 needs 64 bits once DIGITS reaches 10.
    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    function automatic logic [HW-1:0] reset_hex();
        logic [HW-1:0] h;
        h = '0;
        for (int k = 0; k < DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
            h[7*k +: 7] = (k == 0) ? SEG_ZERO : SEG_BLANK;
`else
            h[7*k +: 7] = SEG_ZERO;
`endif
        end
        return h;
    endfunction

    localparam logic [63:0]   MAX_VALUE = max_value(DIGITS);
    localparam logic [HW-1:0] HEX_RESET = reset_hex();

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   bcd_q, bcd_d;
    logic [HW-1:0]   hex_q, hex_d;

    logic [AW-1:0]   acc_adj;
    logic [HW-1:0]   seg_raw;
    logic [HW-1:0]   hex_next;

    // Per-digit add-3 with no carry between digits.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        sevenseg u_sevenseg (
            .digit (acc_q[4*g +: 4]),
            .seg   (seg_raw[7*g +: 7])
        );
    end

    // Walk from the top digit down so "all zeros above" is known per digit.
    always_comb begin
        logic zero_above;
        logic [3:0] dig;
        hex_next   = '1;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = acc_q[4*i +: 4];
            if (ovf_pend_q) begin
                hex_next[7*i +: 7] = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
            end else if ((i > 0) && zero_above && (dig == 4'd0)) begin
                hex_next[7*i +: 7] = SEG_BLANK;
`endif
            end else begin
                hex_next[7*i +: 7] = seg_raw[7*i +: 7];
            end
            zero_above = zero_above && (dig == 4'd0);
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        hex_d      = hex_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d       = value;
                    acc_d      = '0;
                    count_d    = CW'(WIDTH);
                    ovf_pend_d = (64'(value) > MAX_VALUE);
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d   = {acc_adj[AW-2:0], sr_q[WIDTH-1]};
                sr_d    = sr_q << 1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d      = acc_q;
                hex_d      = hex_next;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            hex_q      <= HEX_RESET;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            hex_q      <= hex_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd      = bcd_q;
    assign hex      = hex_q;

endmodule

// File: tb/tb_multidigit_bcd_display.sv
// Scoreboard bench for multidigit_bcd_display: a 3-digit and a 2-digit instance (both WIDTH=8).
// Expected hex honours LEADING_ZERO_BLANK_EN when the bundle is built with it.

module tb_multidigit_bcd_display;
    logic clock = 1'b0;
    logic reset;
    logic [7:0] value3, value2;
    logic start3, start2;
    logic busy3, done3, ovf3, busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [20:0] hex3;
    logic [7:0]  bcd2;
    logic [13:0] hex2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [11:0] bcd;
        logic [20:0] hex;
        logic        ovf;
        int          cyc;
    } exp3_t;

    typedef struct {
        logic [7:0]  bcd;
        logic [13:0] hex;
        logic        ovf;
        int          cyc;
    } exp2_t;

    exp3_t q3[$];
    exp2_t q2[$];

    multidigit_bcd_display #(.WIDTH(8), .DIGITS(3)) u_d3 (
        .clock(clock), .reset(reset), .value(value3), .start(start3),
        .busy(busy3), .done(done3), .overflow(ovf3), .bcd(bcd3), .hex(hex3)
    );

    multidigit_bcd_display #(.WIDTH(8), .DIGITS(2)) u_d2 (
        .clock(clock), .reset(reset), .value(value2), .start(start2),
        .busy(busy2), .done(done2), .overflow(ovf2), .bcd(bcd2), .hex(hex2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [69:0] exp_hex(input logic [39:0] b, input int n, input bit ovf);
        logic [69:0] h;
        logic [3:0]  d;
        logic [6:0]  s;
        bit          lead;
        h = '1;
        lead = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            s = seg_of(d);
            if (ovf) s = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
            else if (i > 0 && lead && d == 4'd0) s = 7'b1111111;
`endif
            h[7*i +: 7] = s;
            lead = lead && (d == 4'd0);
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && done3) begin
            if (q3.size() == 0) begin
                chk("d3_unexpected_done", 1, 0);
            end else begin
                exp3_t e;
                logic [69:0] hx;
                e = q3.pop_front();
                hx = exp_hex({28'd0, e.bcd}, 3, e.ovf);
                chk("d3_bcd", bcd3, e.bcd);
                chk("d3_hex", hex3, hx[20:0]);
                chk("d3_overflow", ovf3, e.ovf);
                chk("d3_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && done2) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_done", 1, 0);
            end else begin
                exp2_t e;
                logic [69:0] hx;
                e = q2.pop_front();
                hx = exp_hex({32'd0, e.bcd}, 2, e.ovf);
                chk("d2_bcd", bcd2, e.bcd);
                chk("d2_hex", hex2, hx[13:0]);
                chk("d2_overflow", ovf2, e.ovf);
                chk("d2_latency", cyc, e.cyc);
            end
        end
    end

    // Accept edge is cyc+1; done is visible at the negedge where cyc = accept + WIDTH + 1.
    task automatic go3(input logic [7:0] v, input logic [11:0] eb);
        exp3_t e;
        @(negedge clock);
        value3 = v;
        start3 = 1'b1;
        e.bcd = eb; e.hex = '0; e.ovf = 1'b0; e.cyc = cyc + 10;
        q3.push_back(e);
        @(negedge clock);
        start3 = 1'b0;
        value3 = ~v;
        chk("d3_busy_after_start", busy3, 1);
        repeat (10) @(negedge clock);
    endtask

    task automatic go2(input logic [7:0] v, input logic [7:0] eb, input logic eo);
        exp2_t e;
        @(negedge clock);
        value2 = v;
        start2 = 1'b1;
        e.bcd = eb; e.hex = '0; e.ovf = eo; e.cyc = cyc + 10;
        q2.push_back(e);
        @(negedge clock);
        start2 = 1'b0;
        chk("d2_busy_after_start", busy2, 1);
        repeat (10) @(negedge clock);
    endtask

    initial begin
        logic [69:0] rh;
        exp3_t e;
        reset = 1'b1;
        value3 = '0; value2 = '0;
        start3 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clock);
        rh = exp_hex(40'd0, 3, 1'b0);
        chk("reset_bcd", bcd3, 12'h000);
        chk("reset_hex", hex3, rh[20:0]);
        chk("reset_busy", busy3, 0);
        chk("reset_done", done3, 0);
        chk("reset_overflow", ovf3, 0);
        reset = 1'b0;

        go3(8'd255, 12'h255);
        go3(8'd0,   12'h000);
        go3(8'd5,   12'h005);
        go3(8'd99,  12'h099);
        go3(8'd128, 12'h128);
        chk("d3_idle_not_busy", busy3, 0);

        go2(8'd63,  8'h63, 1'b0);
        go2(8'd100, 8'h00, 1'b1);
        go2(8'd42,  8'h42, 1'b0);
        go2(8'd255, 8'h55, 1'b1);
        go2(8'd99,  8'h99, 1'b0);

        // start held high: second conversion begins right after DONE with the newer value
        @(negedge clock);
        value3 = 8'd17;
        start3 = 1'b1;
        e.bcd = 12'h017; e.hex = '0; e.ovf = 1'b0; e.cyc = cyc + 10;
        q3.push_back(e);
        e.bcd = 12'h201; e.cyc = cyc + 20;
        q3.push_back(e);
        @(negedge clock);
        value3 = 8'd201;
        repeat (10) @(negedge clock);
        start3 = 1'b0;
        value3 = 8'd3;
        repeat (11) @(negedge clock);

        // second start while busy is ignored, then reset aborts the conversion
        value3 = 8'd200;
        start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        value3 = 8'd7;
        start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", busy3, 0);
        chk("abort_done", done3, 0);
        chk("abort_bcd", bcd3, 12'h000);
        chk("abort_hex", hex3, rh[20:0]);
        repeat (14) @(negedge clock);
        chk("abort_stays_idle", busy3, 0);
        go3(8'd7, 12'h007);

        repeat (3) @(negedge clock);
        chk("d3_pending_at_end", q3.size(), 0);
        chk("d2_pending_at_end", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
